// File: rtl/imm_encoder.sv
// Packs a signed 64-bit immediate into the RV64 I/U/S/J/B bit positions of a base
// instruction word, flagging unrepresentable values. Two-stage valid/ready pipeline.
module imm_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [63:0]      in_imm,
  input  logic [31:0]      in_base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_U = 3'd2;
  localparam logic [2:0] FMT_S = 3'd3;
  localparam logic [2:0] FMT_J = 3'd4;
  localparam logic [2:0] FMT_B = 3'd5;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Returns {err, instr}; an errored result always carries the base word untouched.
  function automatic logic [32:0] encode(input logic [2:0] fmt, input logic [63:0] imm,
                                         input logic [31:0] base);
    logic        err;
    logic [31:0] instr;
    err   = 1'b0;
    instr = base;
    case (fmt)
      FMT_I: begin
        err   = !((&imm[63:11]) || !(|imm[63:11]));
        instr = {imm[11:0], base[19:0]};
      end
      FMT_S: begin
        err   = !((&imm[63:11]) || !(|imm[63:11]));
        instr = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
      end
      FMT_B: begin
        err   = !((&imm[63:12]) || !(|imm[63:12])) || imm[0];
        instr = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
      end
      FMT_J: begin
        err   = !((&imm[63:20]) || !(|imm[63:20])) || imm[0];
        instr = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
      end
      FMT_U: begin
        err   = !((&imm[63:31]) || !(|imm[63:31])) || (|imm[11:0]);
        instr = {imm[31:12], base[11:0]};
      end
      default: begin
        err   = 1'b1;
        instr = base;
      end
    endcase
    if (err) begin
      instr = base;
    end else begin
      instr = instr;
    end
    return {err, instr};
  endfunction

  logic             r_s1_valid;
  logic [2:0]       r_s1_fmt;
  logic [63:0]      r_s1_imm;
  logic [31:0]      r_s1_base;
  logic             r_out_valid;
  logic [31:0]      r_out_instr;
  logic             r_out_err;
  logic [CNT_W-1:0] r_err_count;
  logic             w_s2_adv;
  logic             w_accept;
  logic [32:0]      w_enc;

  assign w_s2_adv = !r_out_valid || out_ready;
  assign in_ready = !r_s1_valid || w_s2_adv;
  assign w_accept = in_valid && in_ready;
  assign w_enc    = encode(r_s1_fmt, r_s1_imm, r_s1_base);

  // Stage 1: capture the request; empties when its content moves on with nothing new behind it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_fmt   <= 3'd0;
      r_s1_imm   <= 64'd0;
      r_s1_base  <= 32'd0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_fmt   <= in_fmt;
      r_s1_imm   <= in_imm;
      r_s1_base  <= in_base;
    end else if (w_s2_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Stage 2: registered result, held stable while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_instr <= 32'd0;
      r_out_err   <= 1'b0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_instr <= w_enc[31:0];
        r_out_err   <= w_enc[32];
      end
    end
  end

  // Saturating count of errored results actually handed off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_count <= {CNT_W{1'b0}};
    end else if (r_out_valid && out_ready && r_out_err && (r_err_count != CNT_MAX)) begin
      r_err_count <= r_err_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign out_valid = r_out_valid;
  assign out_instr = r_out_instr;
  assign out_err   = r_out_err;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed and randomized checks for imm_encoder: packing, legality, latency,
// backpressure, reset mid-stream and error-counter saturation.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [63:0] in_imm;
  logic [31:0] in_base;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] err_count;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  logic [63:0] q_imm[$];
  logic [2:0]  q_fmt[$];
  logic [63:0] e_imm;
  logic [2:0]  e_fmt;
  logic [63:0] r;
  int          sent;
  int          recv;
  int          hs;
  logic        took;
  localparam int NRND = 2000;

  always #5 clk = ~clk;

  imm_encoder #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_imm(in_imm), .in_base(in_base),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_err(out_err), .err_count(err_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference decoder: rebuilds the sign-extended immediate from an instruction word.
  function automatic logic [63:0] decode(input logic [31:0] x, input logic [2:0] f);
    case (f)
      3'd1:    return {{52{x[31]}}, x[31:20]};
      3'd3:    return {{52{x[31]}}, x[31:25], x[11:7]};
      3'd5:    return {{51{x[31]}}, x[31], x[7], x[30:25], x[11:8], 1'b0};
      3'd4:    return {{43{x[31]}}, x[31], x[19:12], x[20], x[30:21], 1'b0};
      3'd2:    return {{32{x[31]}}, x[31:12], 12'h000};
      default: return 64'd0;
    endcase
  endfunction

  task automatic send_dir(input string tag, input logic [2:0] f, input logic [63:0] imm,
                          input logic [31:0] base, input logic [31:0] ei, input logic ee);
    @(negedge clk);
    in_valid = 1'b1; in_fmt = f; in_imm = imm; in_base = base;
    #1 check({tag, "_rdy"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_lat1"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_instr"}, 64'(out_instr), 64'(ei));
    check({tag, "_err"}, 64'(out_err), 64'(ee));
    if (ee) exp_cnt++;
    @(negedge clk);
    check({tag, "_drain"}, 64'(out_valid), 64'd0);
    check({tag, "_cnt"}, 64'(err_count), 64'(exp_cnt));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_fmt = 3'd0; in_imm = 64'd0; in_base = 32'd0;
    out_ready = 1'b1; took = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_instr", 64'(out_instr), 64'd0);
    check("rst_err", 64'(out_err), 64'd0);
    check("rst_cnt", 64'(err_count), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;

    // Directed packing / legality vectors.
    send_dir("i_m1",   3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 32'h00000013, 32'hFFF00013, 1'b0);
    send_dir("b_m4",   3'd5, -64'sd4,                 32'h00000063, 32'hFE000EE3, 1'b0);
    send_dir("j_8",    3'd4, 64'd8,                   32'h0000006F, 32'h0080006F, 1'b0);
    send_dir("u_ok",   3'd2, 64'h12345000,            32'h00000037, 32'h12345037, 1'b0);
    send_dir("u_lo",   3'd2, 64'h12345001,            32'h00000037, 32'h00000037, 1'b1);
    send_dir("i_2048", 3'd1, 64'd2048,                32'h00000013, 32'h00000013, 1'b1);
    send_dir("i_m2048",3'd1, -64'sd2048,              32'h00000013, 32'h80000013, 1'b0);
    send_dir("i_2047", 3'd1, 64'd2047,                32'h00000013, 32'h7FF00013, 1'b0);
    send_dir("s_m1",   3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 32'h00000023, 32'hFE000FA3, 1'b0);
    send_dir("b_odd",  3'd5, 64'd3,                   32'h00000063, 32'h00000063, 1'b1);
    send_dir("j_big",  3'd4, 64'h100000,              32'h0000006F, 32'h0000006F, 1'b1);
    send_dir("j_min",  3'd4, -64'sd1048576,           32'h0000006F, 32'h8000006F, 1'b0);
    send_dir("fmt7",   3'd7, 64'd0,                   32'h12345678, 32'h12345678, 1'b1);
    send_dir("fmt0",   3'd0, 64'd4,                   32'h0000ABCD, 32'h0000ABCD, 1'b1);
    send_dir("u_neg",  3'd2, 64'hFFFF_FFFF_8000_0000, 32'h00000037, 32'h80000037, 1'b0);

    // Backpressure: two accepts, then stall with the third item presented.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_fmt = 3'd1; in_imm = 64'd1; in_base = 32'h13;
    #1 check("bp_rdy_a", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_imm = 64'd2;
    #1 check("bp_rdy_b", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_imm = 64'd3;
    #1 check("bp_full", 64'(in_ready), 64'd0);
    check("bp_valid", 64'(out_valid), 64'd1);
    check("bp_instr", 64'(out_instr), 64'h00100013);
    repeat (3) begin
      @(negedge clk);
      check("bp_hold_rdy", 64'(in_ready), 64'd0);
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_instr", 64'(out_instr), 64'h00100013);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1 check("bp_release_rdy", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_out2_valid", 64'(out_valid), 64'd1);
    check("bp_out2_instr", 64'(out_instr), 64'h00200013);
    @(negedge clk);
    check("bp_out3_valid", 64'(out_valid), 64'd1);
    check("bp_out3_instr", 64'(out_instr), 64'h00300013);
    @(negedge clk);
    check("bp_empty", 64'(out_valid), 64'd0);

    // Reset with both stages holding errored items.
    out_ready = 1'b0; in_valid = 1'b1; in_fmt = 3'd7; in_base = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    check("mr_full_valid", 64'(out_valid), 64'd1);
    check("mr_full_rdy", 64'(in_ready), 64'd0);
    check("mr_cnt_before", 64'(err_count), 64'(exp_cnt));
    rst = 1'b1;
    #1;
    check("mr_valid", 64'(out_valid), 64'd0);
    check("mr_cnt", 64'(err_count), 64'd0);
    check("mr_instr", 64'(out_instr), 64'd0);
    check("mr_rdy", 64'(in_ready), 64'd1);
    exp_cnt = 0;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("mr_no_stale", 64'(out_valid), 64'd0);
    end

    // Random legal immediates with random backpressure, scoreboarded.
    sent = 0; recv = 0; took = 1'b0; in_base = 32'd0;
    for (int cyc = 0; cyc < 40000 && recv < NRND; cyc++) begin
      @(negedge clk);
      if (took) in_valid = 1'b0;
      took = 1'b0;
      if (!in_valid && sent < NRND && $urandom_range(3) != 0) begin
        r = {$urandom, $urandom};
        in_fmt = 3'($urandom_range(5, 1));
        in_base = $urandom;
        case (in_fmt)
          3'd1, 3'd3: in_imm = {{52{r[11]}}, r[11:0]};
          3'd5:       in_imm = {{51{r[12]}}, r[12:1], 1'b0};
          3'd4:       in_imm = {{43{r[20]}}, r[20:1], 1'b0};
          default:    in_imm = {{32{r[31]}}, r[31:12], 12'h000};
        endcase
        in_valid = 1'b1;
      end
      out_ready = 1'($urandom_range(1));
      #1;
      if (in_valid && in_ready) begin
        q_imm.push_back(in_imm);
        q_fmt.push_back(in_fmt);
        sent++;
        took = 1'b1;
      end
      if (out_valid && out_ready) begin
        if (q_imm.size() == 0) begin
          check("rnd_extra", 64'(out_valid), 64'd0);
        end else begin
          e_imm = q_imm.pop_front();
          e_fmt = q_fmt.pop_front();
          check("rnd_roundtrip", decode(out_instr, e_fmt), e_imm);
          check("rnd_err", 64'(out_err), 64'd0);
        end
        recv++;
      end
    end
    @(negedge clk);
    if (took) in_valid = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    check("rnd_sent", 64'(sent), 64'(NRND));
    check("rnd_recv", 64'(recv), 64'(NRND));
    check("rnd_queue", 64'(q_imm.size()), 64'd0);
    check("rnd_cnt", 64'(err_count), 64'd0);

    // Drive 2^16+3 and more errors at full rate; counter must stick at all-ones.
    hs = 0;
    in_fmt = 3'd7; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 65545; c++) begin
      @(negedge clk);
      if (hs == 65534) check("sat_pre", 64'(err_count), 64'd65534);
      if (out_valid && out_ready && out_err) hs++;
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("sat_enough", 64'(hs >= 65539), 64'd1);
    check("sat_cnt", 64'(err_count), 64'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
